switch_box_cfg: RTL and testbench
=================================

# switch_box_cfg

Parametrised, runtime-configurable switch box for the FPGA routing fabric. It connects four wire sides (top, right, bottom, left) through one programmable source selector per output wire. The routing configuration is loaded word-by-word through a valid/ready stream into shadow registers, checked, and only then committed atomically to the active configuration. It replaces the fixed, initial-block-configured matrix tiles and sits between adjacent CLB tiles, with the config stream daisy-fed from the fabric configuration controller.

## Interface
Parameters:
- W_TB, 5, wires on top and bottom sides
- W_LR, 4, wires on left and right sides
- REG_OUT, 0, 0 = combinational routing, 1 = routed outputs registered (1-cycle latency)
- IW, derived = max(1, clog2(max(W_TB,W_LR))), source-index width
- CW, derived = 3+IW, config entry width: [CW-1:3] index, [2:0] side code
- N, derived = 2*W_TB+2*W_LR, entries per full configuration

Ports (one clock `clk`; reset `rst_n` is asynchronous, active-low):
- clk  in  1  fabric clock
- rst_n  in  1  async active-low reset
- top_in / bot_in  in  W_TB  wire values arriving on top/bottom side
- rgt_in / lft_in  in  W_LR  wire values arriving on right/left side
- top_out / bot_out  out  W_TB  routed values driven onto top/bottom wires
- top_oe / bot_oe  out  W_TB  per-wire drive enable (pad/tristate enable outside block)
- rgt_out, lft_out, rgt_oe, lft_oe  out  W_LR  same for right/left
- cfg_start  in  1  pulse: begin (or restart) a configuration load
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  block accepts cfg_data
- cfg_data  in  CW  one config entry
- cfg_done  out  1  1-cycle pulse: new configuration committed
- cfg_err  out  1  sticky: last load rejected; cleared by next cfg_start

## Operation
- Side codes: 0 off, 1 top, 2 right, 3 bottom, 4 left; 5–7 illegal.
- Entry order: top[0..W_TB-1], right[0..W_LR-1], bottom[0..W_TB-1], left[0..W_LR-1].
- Routing uses *_in buses only; outputs never feed other outputs, so no combinational loops.
- For each output wire with an active entry (code c, index k): out = selected side's in[k], oe = 1. For code 0: out = 0, oe = 0.
- FSM states:
  - IDLE: cfg_ready = 0. cfg_start goes to LOAD, clears cfg_err, and resets the entry counter.
  - LOAD: cfg_ready = 1. Each valid&ready beat writes shadow[cnt] and increments cnt. The beat with cnt = N-1 goes to CHECK.
  - CHECK: 1 cycle. The shadow configuration is illegal if any entry has a code of 5–7, has an index ≥ the source side's width, or selects its own wire (same side and same index). Illegal goes to IDLE with cfg_err = 1 and the active configuration unchanged. Legal goes to COMMIT.
  - COMMIT: 1 cycle. All active entries are set from shadow simultaneously, cfg_done pulses, then the FSM returns to IDLE.
- cfg_start in LOAD aborts the current load and restarts it at cnt = 0; shadow contents are don't-care.
- cfg_start in CHECK or COMMIT is ignored.
- Routing continues on the old active configuration throughout LOAD and CHECK. There is no glitch window.

## Timing
- Reset values: active entries all 0 (every oe = 0, every out = 0), FSM = IDLE, cfg_ready = 0, cfg_done = 0, cfg_err = 0, cnt = 0.
- Reset asserted mid-load discards the load entirely. No partial commit.
- Load latency: N accepted beats, then 1 cycle CHECK, then 1 cycle COMMIT. cfg_done is high in the COMMIT cycle.
- New routing is visible at out/oe:
  - REG_OUT = 0: the cycle after COMMIT.
  - REG_OUT = 1: two cycles after COMMIT.
- Data path:
  - REG_OUT = 0: in to out purely combinational.
  - REG_OUT = 1: out/oe registered, 1-cycle latency; register resets to 0.
- cfg_valid while cfg_ready = 0 is ignored; data is not held.

## Structure
- Package `switch_box_pkg`:
  - side-code localparams (SIDE_OFF, SIDE_TOP, SIDE_RGT, SIDE_BOT, SIDE_LFT)
  - index-width function
  - FSM state enum (IDLE, LOAD, CHECK, COMMIT)
- Sub-module `switch_sel`: one output wire's source mux plus legality flag. Inputs are the entry and the four in buses; outputs are val, oe, and illegal.
- Top level instantiates N `switch_sel` for the active configuration. Legality checking reuses N combinational checks on shadow.

## Test plan
Defaults W_TB = 5, W_LR = 4, N = 18, CW = 6.
- Reset then idle → every oe = 0, every out = 0, cfg_ready = 0.
- Load 18 entries with top[0] = {idx 2, code 4} and all others 0; drive lft_in = 4'b0100 → cfg_done one cycle after CHECK; top_oe = 5'b00001; top_out[0] = 1; toggling lft_in[2] follows on top_out[0].
- Load with entry right[3] = {idx 4, code 2} (index ≥ W_LR) → cfg_err = 1, no cfg_done, previous routing unchanged.
- Self-route bottom[1] = {idx 1, code 3} → rejected with cfg_err = 1.
- Pulse cfg_start after 7 beats, then send a full valid 18-beat load → single commit of the second configuration only.
- REG_OUT = 1, route bot[4] ← top[0] → bot_out[4] follows top_in[0] with exactly 1 cycle delay.
- Assert rst_n low at beat 10 of a load → all oe = 0 immediately; no cfg_done after release.

Source files
------------

// File: rtl/switch_box_pkg.sv
// Shared side codes, FSM states and width helper for the configurable switch box.
package switch_box_pkg;

  localparam logic [2:0] SIDE_OFF = 3'd0;
  localparam logic [2:0] SIDE_TOP = 3'd1;
  localparam logic [2:0] SIDE_RGT = 3'd2;
  localparam logic [2:0] SIDE_BOT = 3'd3;
  localparam logic [2:0] SIDE_LFT = 3'd4;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

  // Source-index width: enough bits to address the widest side, never below 1.
  function automatic int idx_w(input int w_tb, input int w_lr);
    int m;
    m = (w_tb > w_lr) ? w_tb : w_lr;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/switch_sel.sv
// One output wire: decodes a config entry into a source mux, drive enable and legality flag.
module switch_sel
  import switch_box_pkg::*;
#(
  parameter int         W_TB     = 5,
  parameter int         W_LR     = 4,
  parameter int         IW       = 3,
  parameter logic [2:0] OWN_SIDE = SIDE_TOP,
  parameter int         OWN_IDX  = 0
) (
  input  logic [IW+2:0]   entry,
  input  logic [W_TB-1:0] top_in,
  input  logic [W_LR-1:0] rgt_in,
  input  logic [W_TB-1:0] bot_in,
  input  logic [W_LR-1:0] lft_in,
  output logic            val,
  output logic            oe,
  output logic            illegal
);

  // Buses padded to a full power of two so any index reads a defined 0 when out of range.
  localparam int EW = 1 << IW;

  logic [2:0]    code;
  logic [IW-1:0] idx;
  logic [EW-1:0] top_x, rgt_x, bot_x, lft_x;
  logic          sel;

  assign code  = entry[2:0];
  assign idx   = entry[IW+2:3];
  assign top_x = EW'(top_in);
  assign rgt_x = EW'(rgt_in);
  assign bot_x = EW'(bot_in);
  assign lft_x = EW'(lft_in);

  always_comb begin
    sel     = 1'b0;
    illegal = 1'b0;
    case (code)
      SIDE_OFF: sel = 1'b0;
      SIDE_TOP: begin sel = top_x[idx]; illegal = int'(idx) >= W_TB; end
      SIDE_RGT: begin sel = rgt_x[idx]; illegal = int'(idx) >= W_LR; end
      SIDE_BOT: begin sel = bot_x[idx]; illegal = int'(idx) >= W_TB; end
      SIDE_LFT: begin sel = lft_x[idx]; illegal = int'(idx) >= W_LR; end
      default:  illegal = 1'b1;
    endcase
    if (code == OWN_SIDE && int'(idx) == OWN_IDX) illegal = 1'b1;
  end

  assign oe  = (code != SIDE_OFF) && !illegal;
  assign val = sel && oe;

endmodule

// File: rtl/switch_box_cfg.sv
// Runtime-configurable switch box: streamed shadow config, legality check, atomic commit.
module switch_box_cfg
  import switch_box_pkg::*;
#(
  parameter int W_TB    = 5,
  parameter int W_LR    = 4,
  parameter int REG_OUT = 0,
  parameter int IW      = idx_w(W_TB, W_LR),
  parameter int CW      = 3 + IW,
  parameter int N       = 2*W_TB + 2*W_LR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W_TB-1:0] top_in,
  input  logic [W_TB-1:0] bot_in,
  input  logic [W_LR-1:0] rgt_in,
  input  logic [W_LR-1:0] lft_in,
  output logic [W_TB-1:0] top_out,
  output logic [W_TB-1:0] bot_out,
  output logic [W_TB-1:0] top_oe,
  output logic [W_TB-1:0] bot_oe,
  output logic [W_LR-1:0] rgt_out,
  output logic [W_LR-1:0] lft_out,
  output logic [W_LR-1:0] rgt_oe,
  output logic [W_LR-1:0] lft_oe,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CW-1:0]   cfg_data,
  output logic            cfg_done,
  output logic            cfg_err
);

  localparam int CNTW = $clog2(N);

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   act [N];
  logic [CW-1:0]   shd [N];
  logic [N-1:0]    act_val, act_oe, act_ill;
  logic [N-1:0]    shd_val, shd_oe, shd_ill;
  logic [N-1:0]    route_val, route_oe;
  logic            beat;
  logic            unused_sel;

  assign cfg_ready = (state == LOAD);
  assign cfg_done  = (state == COMMIT);
  assign beat      = cfg_valid && cfg_ready && !cfg_start;

  // Entry j maps to side/index in the order top, right, bottom, left.
  for (genvar j = 0; j < N; j++) begin : g_sel
    localparam logic [2:0] SIDE = (j < W_TB)          ? SIDE_TOP :
                                  (j < W_TB+W_LR)     ? SIDE_RGT :
                                  (j < 2*W_TB+W_LR)   ? SIDE_BOT : SIDE_LFT;
    localparam int         IDX  = (j < W_TB)          ? j :
                                  (j < W_TB+W_LR)     ? j - W_TB :
                                  (j < 2*W_TB+W_LR)   ? j - W_TB - W_LR : j - 2*W_TB - W_LR;

    switch_sel #(.W_TB(W_TB), .W_LR(W_LR), .IW(IW), .OWN_SIDE(SIDE), .OWN_IDX(IDX)) u_act (
      .entry(act[j]), .top_in(top_in), .rgt_in(rgt_in), .bot_in(bot_in), .lft_in(lft_in),
      .val(act_val[j]), .oe(act_oe[j]), .illegal(act_ill[j])
    );

    switch_sel #(.W_TB(W_TB), .W_LR(W_LR), .IW(IW), .OWN_SIDE(SIDE), .OWN_IDX(IDX)) u_chk (
      .entry(shd[j]), .top_in(top_in), .rgt_in(rgt_in), .bot_in(bot_in), .lft_in(lft_in),
      .val(shd_val[j]), .oe(shd_oe[j]), .illegal(shd_ill[j])
    );
  end

  // Active entries are always legal; only the shadow copies' legality is consumed.
  assign unused_sel = ^{act_ill, shd_val, shd_oe};

  always_ff @(posedge clk) begin
    if (beat) shd[cnt] <= cfg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      cfg_err <= 1'b0;
      for (int j = 0; j < N; j++) act[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state   <= LOAD;
            cnt     <= '0;
            cfg_err <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            cnt <= '0;
          end else if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNTW'(N-1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (|shd_ill) begin
            state   <= IDLE;
            cfg_err <= 1'b1;
          end else begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          act   <= shd;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [N-1:0] val_p1, oe_p1;
    // Stage p0 -> p1: registered routed outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_p1 <= '0;
        oe_p1  <= '0;
      end else begin
        val_p1 <= act_val;
        oe_p1  <= act_oe;
      end
    end
    assign route_val = val_p1;
    assign route_oe  = oe_p1;
  end else begin : g_comb
    assign route_val = act_val;
    assign route_oe  = act_oe;
  end

  assign top_out = route_val[W_TB-1:0];
  assign rgt_out = route_val[W_TB+W_LR-1:W_TB];
  assign bot_out = route_val[2*W_TB+W_LR-1:W_TB+W_LR];
  assign lft_out = route_val[N-1:2*W_TB+W_LR];
  assign top_oe  = route_oe[W_TB-1:0];
  assign rgt_oe  = route_oe[W_TB+W_LR-1:W_TB];
  assign bot_oe  = route_oe[2*W_TB+W_LR-1:W_TB+W_LR];
  assign lft_oe  = route_oe[N-1:2*W_TB+W_LR];

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed bench for switch_box_cfg: one combinational and one registered-output instance share stimulus.
module tb_switch_box_cfg;

  localparam int W_TB = 5;
  localparam int W_LR = 4;
  localparam int N    = 18;
  localparam int CW   = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W_TB-1:0] top_in = '0, bot_in = '0;
  logic [W_LR-1:0] rgt_in = '0, lft_in = '0;
  logic            cfg_start = 1'b0, cfg_valid = 1'b0;
  logic [CW-1:0]   cfg_data = '0;

  logic [W_TB-1:0] d0_top_out, d0_bot_out, d0_top_oe, d0_bot_oe;
  logic [W_LR-1:0] d0_rgt_out, d0_lft_out, d0_rgt_oe, d0_lft_oe;
  logic            d0_rdy, d0_done, d0_err;
  logic [W_TB-1:0] d1_top_out, d1_bot_out, d1_top_oe, d1_bot_oe;
  logic [W_LR-1:0] d1_rgt_out, d1_lft_out, d1_rgt_oe, d1_lft_oe;
  logic            d1_rdy, d1_done, d1_err;

  switch_box_cfg #(.W_TB(W_TB), .W_LR(W_LR), .REG_OUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .top_in(top_in), .bot_in(bot_in), .rgt_in(rgt_in), .lft_in(lft_in),
    .top_out(d0_top_out), .bot_out(d0_bot_out), .top_oe(d0_top_oe), .bot_oe(d0_bot_oe),
    .rgt_out(d0_rgt_out), .lft_out(d0_lft_out), .rgt_oe(d0_rgt_oe), .lft_oe(d0_lft_oe),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(d0_rdy), .cfg_data(cfg_data),
    .cfg_done(d0_done), .cfg_err(d0_err)
  );

  switch_box_cfg #(.W_TB(W_TB), .W_LR(W_LR), .REG_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .top_in(top_in), .bot_in(bot_in), .rgt_in(rgt_in), .lft_in(lft_in),
    .top_out(d1_top_out), .bot_out(d1_bot_out), .top_oe(d1_top_oe), .bot_oe(d1_bot_oe),
    .rgt_out(d1_rgt_out), .lft_out(d1_lft_out), .rgt_oe(d1_rgt_oe), .lft_oe(d1_lft_oe),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(d1_rdy), .cfg_data(cfg_data),
    .cfg_done(d1_done), .cfg_err(d1_err)
  );

  // Bit j of these vectors is output wire j in entry order (top, right, bottom, left).
  logic [N-1:0] oe0, out0, oe1, out1;
  assign oe0  = {d0_lft_oe,  d0_bot_oe,  d0_rgt_oe,  d0_top_oe};
  assign out0 = {d0_lft_out, d0_bot_out, d0_rgt_out, d0_top_out};
  assign oe1  = {d1_lft_oe,  d1_bot_oe,  d1_rgt_oe,  d1_top_oe};
  assign out1 = {d1_lft_out, d1_bot_out, d1_rgt_out, d1_top_out};

  int errors = 0;
  int checks = 0;
  logic [CW-1:0] cfg_vec [N];

  function automatic logic [CW-1:0] ent(input int idx, input int code);
    return {idx[2:0], code[2:0]};
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) cfg_vec[i] = '0;
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send_beats(input int from, input int count);
    for (int i = 0; i < count; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = cfg_vec[from+i];
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
  endtask

  task automatic finish_load(output int dones);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (d0_done) dones++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    top_in = '1; bot_in = '1; rgt_in = '1; lft_in = '1;
    #3;
    checks++;
    if ({oe0, oe1} !== '0) begin errors++; $display("FAIL reset_oe: got %h %h want 0", oe0, oe1); end
    checks++;
    if ({out0, out1} !== '0) begin errors++; $display("FAIL reset_out: got %h %h want 0", out0, out1); end
    checks++;
    if ({d0_rdy, d0_done, d0_err, d1_rdy, d1_done, d1_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {d0_rdy, d0_done, d0_err, d1_rdy, d1_done, d1_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cfg_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    checks++;
    if ({oe0, oe1, d0_rdy, d1_rdy} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got oe %h %h rdy %b%b want all 0", oe0, oe1, d0_rdy, d1_rdy);
    end
  endtask

  task automatic test_route();
    clear_cfg();
    cfg_vec[0] = ent(2, 4);
    lft_in = 4'b0100;
    start_pulse();
    checks++;
    if (d0_rdy !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", d0_rdy); end
    send_beats(0, N);
    checks++;
    if ({d0_done, d0_rdy} !== 2'b00) begin errors++; $display("FAIL check_cycle: got done,rdy %b want 00", {d0_done, d0_rdy}); end
    @(posedge clk); #1;
    checks++;
    if ({d0_done, d1_done} !== 2'b11) begin errors++; $display("FAIL done_pulse: got %b want 11", {d0_done, d1_done}); end
    checks++;
    if (oe0 !== '0) begin errors++; $display("FAIL old_route_in_commit: got %h want 0", oe0); end
    @(posedge clk); #1;
    checks++;
    if (d0_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", d0_done); end
    checks++;
    if ({oe0, out0} !== {18'h00001, 18'h00001}) begin errors++; $display("FAIL route_comb: got oe %h out %h want 00001 00001", oe0, out0); end
    checks++;
    if (oe1 !== '0) begin errors++; $display("FAIL route_reg_lag: got %h want 0", oe1); end
    @(posedge clk); #1;
    checks++;
    if ({oe1, out1} !== {18'h00001, 18'h00001}) begin errors++; $display("FAIL route_reg: got oe %h out %h want 00001 00001", oe1, out1); end
    lft_in = 4'b0000; #1;
    checks++;
    if (out0 !== '0) begin errors++; $display("FAIL follow_low: got %h want 0", out0); end
    lft_in = 4'b0100; #1;
    checks++;
    if (out0 !== 18'h00001) begin errors++; $display("FAIL follow_high: got %h want 00001", out0); end
    checks++;
    if (d0_err !== 1'b0) begin errors++; $display("FAIL route_err: got %b want 0", d0_err); end
  endtask

  task automatic test_multi();
    int dones;
    clear_cfg();
    cfg_vec[0]  = ent(3, 4);
    cfg_vec[5]  = ent(4, 1);
    cfg_vec[11] = ent(3, 2);
    cfg_vec[17] = ent(0, 3);
    top_in = 5'b10000; rgt_in = 4'b1000; bot_in = 5'b00000; lft_in = 4'b0000;
    start_pulse();
    send_beats(0, N);
    finish_load(dones);
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL multi_done: got %0d want 1", dones); end
    checks++;
    if (oe0 !== 18'h20821) begin errors++; $display("FAIL multi_oe: got %h want 20821", oe0); end
    checks++;
    if (out0 !== 18'h00820) begin errors++; $display("FAIL multi_out_a: got %h want 00820", out0); end
    top_in = 5'b00000; rgt_in = 4'b0000; bot_in = 5'b00001; lft_in = 4'b1000; #1;
    checks++;
    if (out0 !== 18'h20001) begin errors++; $display("FAIL multi_out_b: got %h want 20001", out0); end
  endtask

  task automatic test_bad_index();
    int dones;
    clear_cfg();
    cfg_vec[8] = ent(4, 2);
    start_pulse();
    send_beats(0, N);
    finish_load(dones);
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL badidx_done: got %0d want 0", dones); end
    checks++;
    if ({d0_err, d1_err} !== 2'b11) begin errors++; $display("FAIL badidx_err: got %b want 11", {d0_err, d1_err}); end
    checks++;
    if (oe0 !== 18'h20821) begin errors++; $display("FAIL badidx_keep: got %h want 20821", oe0); end
  endtask

  task automatic test_self_route();
    int dones;
    clear_cfg();
    cfg_vec[10] = ent(1, 3);
    start_pulse();
    checks++;
    if (d0_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", d0_err); end
    send_beats(0, N);
    finish_load(dones);
    checks++;
    if ({dones[0], d0_err} !== 2'b01) begin errors++; $display("FAIL self_reject: got dones %0d err %b want 0 1", dones, d0_err); end
    clear_cfg();
    cfg_vec[3] = ent(0, 5);
    start_pulse();
    send_beats(0, N);
    finish_load(dones);
    checks++;
    if ({dones[0], d0_err} !== 2'b01) begin errors++; $display("FAIL code5_reject: got dones %0d err %b want 0 1", dones, d0_err); end
    checks++;
    if (oe0 !== 18'h20821) begin errors++; $display("FAIL reject_keep: got %h want 20821", oe0); end
  endtask

  task automatic test_restart();
    int dones;
    clear_cfg();
    cfg_vec[1] = ent(3, 3);
    start_pulse();
    send_beats(0, 7);
    start_pulse();
    clear_cfg();
    cfg_vec[2]  = ent(1, 2);
    cfg_vec[10] = ent(0, 3);
    top_in = 5'b00000; rgt_in = 4'b0010; bot_in = 5'b01001; lft_in = 4'b0000;
    send_beats(0, N);
    finish_load(dones);
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL restart_done: got %0d want 1", dones); end
    checks++;
    if ({oe0, out0} !== {18'h00404, 18'h00404}) begin errors++; $display("FAIL restart_route: got oe %h out %h want 00404 00404", oe0, out0); end
    checks++;
    if (d0_err !== 1'b0) begin errors++; $display("FAIL restart_err: got %b want 0", d0_err); end
  endtask

  task automatic test_reg_out();
    clear_cfg();
    cfg_vec[13] = ent(0, 1);
    top_in = '0; rgt_in = '0; bot_in = '0; lft_in = '0;
    start_pulse();
    send_beats(0, N);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({oe0, oe1} !== {18'h02000, 18'h00404}) begin errors++; $display("FAIL regout_commit_lag: got %h %h want 02000 00404", oe0, oe1); end
    @(posedge clk); #1;
    checks++;
    if (oe1 !== 18'h02000) begin errors++; $display("FAIL regout_oe: got %h want 02000", oe1); end
    top_in = 5'b00001; #1;
    checks++;
    if ({d0_bot_out[4], d1_bot_out[4]} !== 2'b10) begin errors++; $display("FAIL regout_delay_rise: got %b want 10", {d0_bot_out[4], d1_bot_out[4]}); end
    @(posedge clk); #1;
    checks++;
    if (d1_bot_out[4] !== 1'b1) begin errors++; $display("FAIL regout_rise: got %b want 1", d1_bot_out[4]); end
    top_in = 5'b00000; #1;
    checks++;
    if ({d0_bot_out[4], d1_bot_out[4]} !== 2'b01) begin errors++; $display("FAIL regout_delay_fall: got %b want 01", {d0_bot_out[4], d1_bot_out[4]}); end
    @(posedge clk); #1;
    checks++;
    if (d1_bot_out[4] !== 1'b0) begin errors++; $display("FAIL regout_fall: got %b want 0", d1_bot_out[4]); end
  endtask

  task automatic test_reset_mid_load();
    int dones;
    clear_cfg();
    cfg_vec[0] = ent(2, 4);
    lft_in = 4'b0100; top_in = 5'b00001;
    start_pulse();
    send_beats(0, 10);
    rst_n = 1'b0; #1;
    checks++;
    if ({oe0, oe1, out1} !== '0) begin errors++; $display("FAIL midreset_oe: got %h %h %h want 0", oe0, oe1, out1); end
    checks++;
    if ({d0_rdy, d1_rdy} !== 2'b00) begin errors++; $display("FAIL midreset_rdy: got %b want 00", {d0_rdy, d1_rdy}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beats(10, 8);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (d0_done || d1_done) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midreset_done: got %0d want 0", dones); end
    checks++;
    if ({oe0, oe1} !== '0) begin errors++; $display("FAIL midreset_after: got %h %h want 0", oe0, oe1); end
  endtask

  initial begin
    test_reset();
    test_route();
    test_multi();
    test_bad_index();
    test_self_route();
    test_restart();
    test_reg_out();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
